issue_queue: RTL and testbench

Single-port, age-ordered issue queue placed directly upstream of the operand-load stage. It buffers renamed uops and tracks whether each source operand is available by snooping the writeback ports. Each cycle it selects the oldest uop whose operands are both ready and drives it as a registered `IS_UOp` into the operand-load stage. It honours that stage's per-port stall and flushes entries younger than a mispredicted branch.

---
 rtl/issue_queue_pkg.sv | 42 ++++
 rtl/issue_queue_if.sv | 26 ++
 rtl/issue_queue_prio_enc_lsb.sv | 19 +
 rtl/issue_queue.sv | 146 ++++++++++++++
 tb/tb_issue_queue.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/issue_queue_pkg.sv
// Shared issue-stage types: uop bundles, queue entry and age compare.
// sqN ordering is modular, so every flush site uses sqn_younger.
package issue_queue_pkg;
  localparam int SQN_W = 7;
  localparam int TAG_W = 7;

  typedef logic [SQN_W-1:0] SqN;
  typedef logic [TAG_W-1:0] Tag;

  typedef struct packed {
    logic       valid;
    SqN         sqN;
    Tag         tagA;
    Tag         tagB;
    Tag         tagDst;
    logic       immB;
    logic [7:0] op;
  } IS_UOp;

  typedef struct packed {
    Tag          tagDst;
    logic [31:0] result;
  } RES_UOp;

  typedef struct packed {
    logic taken;
    SqN   sqN;
  } BranchProv;

  typedef struct packed {
    logic  valid;
    IS_UOp uop;
    logic  rdyA;
    logic  rdyB;
  } IQEntry;

  function automatic logic sqn_younger(SqN a, SqN b);
    SqN d;
    d = a - b;
    return $signed(d) > 0;
  endfunction
endpackage

// File: rtl/issue_queue_if.sv
// Enqueue handshake between rename and the issue queue.
// master = rename side, slave = queue side.
interface issue_queue_if
  import issue_queue_pkg::*;
#(
  parameter int SIZE = 8
);
  localparam int FREE_W = $clog2(SIZE) + 1;

  logic              IN_valid;
  IS_UOp             IN_uop;
  logic              IN_availA;
  logic              IN_availB;
  logic              OUT_ready;
  logic [FREE_W-1:0] OUT_free;

  modport master (
    output IN_valid, IN_uop, IN_availA, IN_availB,
    input  OUT_ready, OUT_free
  );

  modport slave (
    input  IN_valid, IN_uop, IN_availA, IN_availB,
    output OUT_ready, OUT_free
  );
endinterface

// File: rtl/issue_queue_prio_enc_lsb.sv
// Lowest-set-bit priority encoder used for oldest-ready select.
module prio_enc_lsb #(
  parameter int W = 8
) (
  input  logic [W-1:0]         i_req,
  output logic [$clog2(W)-1:0] o_idx,
  output logic                 o_valid
);
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx   = $clog2(W)'(i);
        o_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/issue_queue.sv
// Age-ordered compacting issue queue with writeback wakeup,
// oldest-ready select, stall hold and branch flush.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int SIZE    = 8,
  parameter int NUM_WBS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  issue_queue_if.slave         enq,
  input  logic [NUM_WBS-1:0]   IN_wbHasResult,
  input  RES_UOp               IN_wbUOp [NUM_WBS],
  input  BranchProv            IN_branch,
  input  logic                 IN_stall,
  output IS_UOp                OUT_uop
);
  localparam int IDX_W = $clog2(SIZE);
  localparam int CNT_W = IDX_W + 1;

  IQEntry             r_q [SIZE];
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_free;
  IS_UOp              r_out;

  IQEntry             w_wake [SIZE+1];
  IQEntry             w_next [SIZE];
  Tag [NUM_WBS-1:0]   w_wbTag;
  logic               w_unused_res;
  logic [SIZE-1:0]    w_req;
  logic [IDX_W-1:0]   w_selIdx;
  logic               w_selValid;
  logic               w_outFlush;
  logic               w_doIssue;
  logic               w_enq;
  logic               w_inRdyA;
  logic               w_inRdyB;
  logic [CNT_W-1:0]   w_keep;
  logic [CNT_W-1:0]   w_nextCount;
  IS_UOp              w_nextOut;

  function automatic logic wakeup(
    Tag t, logic [NUM_WBS-1:0] v, Tag [NUM_WBS-1:0] tags
  );
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < NUM_WBS; j++)
      hit |= v[j] & (tags[j] == t);
    return hit & ~t[TAG_W-1];
  endfunction

  always_comb begin
    w_unused_res = 1'b0;
    for (int j = 0; j < NUM_WBS; j++) begin
      w_wbTag[j]   = IN_wbUOp[j].tagDst;
      w_unused_res = w_unused_res ^ (^IN_wbUOp[j].result);
    end
  end

  // select uses the pre-wakeup ready bits: wakeup lands at this edge
  always_comb begin
    w_wake[SIZE] = '0;
    for (int i = 0; i < SIZE; i++) begin
      w_wake[i] = r_q[i];
      if (wakeup(r_q[i].uop.tagA, IN_wbHasResult, w_wbTag))
        w_wake[i].rdyA = 1'b1;
      if (wakeup(r_q[i].uop.tagB, IN_wbHasResult, w_wbTag))
        w_wake[i].rdyB = 1'b1;
      w_req[i] = r_q[i].valid & r_q[i].rdyA & r_q[i].rdyB;
    end
  end

  prio_enc_lsb #(.W(SIZE)) u_sel (
    .i_req   (w_req),
    .o_idx   (w_selIdx),
    .o_valid (w_selValid)
  );

  assign w_outFlush = r_out.valid & IN_branch.taken
                    & sqn_younger(r_out.sqN, IN_branch.sqN);
  assign w_doIssue  = w_selValid & (~IN_stall | w_outFlush);

  assign enq.OUT_ready = r_count < CNT_W'(SIZE);
  assign enq.OUT_free  = r_free;
  assign OUT_uop       = r_out;

  assign w_inRdyA = enq.IN_availA | enq.IN_uop.tagA[TAG_W-1]
                  | wakeup(enq.IN_uop.tagA, IN_wbHasResult, w_wbTag);
  assign w_inRdyB = enq.IN_availB | enq.IN_uop.tagB[TAG_W-1]
                  | enq.IN_uop.immB
                  | wakeup(enq.IN_uop.tagB, IN_wbHasResult, w_wbTag);
  assign w_enq = enq.IN_valid & enq.OUT_ready
               & ~(IN_branch.taken
                   & sqn_younger(enq.IN_uop.sqN, IN_branch.sqN));

  // entries are age-ordered, so the flushed set is always a suffix
  always_comb begin
    w_keep = '0;
    for (int i = 0; i < SIZE; i++) begin
      w_next[i] = w_wake[i];
      if (w_doIssue && i >= int'(w_selIdx))
        w_next[i] = w_wake[i+1];
      if (IN_branch.taken && w_next[i].valid
          && sqn_younger(w_next[i].uop.sqN, IN_branch.sqN))
        w_next[i] = '0;
      if (w_next[i].valid)
        w_keep = w_keep + 1'b1;
    end
    if (w_enq) begin
      w_next[w_keep[IDX_W-1:0]].valid = 1'b1;
      w_next[w_keep[IDX_W-1:0]].uop   = enq.IN_uop;
      w_next[w_keep[IDX_W-1:0]].rdyA  = w_inRdyA;
      w_next[w_keep[IDX_W-1:0]].rdyB  = w_inRdyB;
    end
    w_nextCount = w_keep + CNT_W'(w_enq);
  end

  always_comb begin
    w_nextOut = r_out;
    if (w_outFlush || !IN_stall) begin
      w_nextOut       = 'x;
      w_nextOut.valid = 1'b0;
      if (w_doIssue && !(IN_branch.taken
          && sqn_younger(r_q[w_selIdx].uop.sqN, IN_branch.sqN))) begin
        w_nextOut       = r_q[w_selIdx].uop;
        w_nextOut.valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SIZE; i++)
        r_q[i] <= '0;
      r_count <= '0;
      r_free  <= CNT_W'(SIZE);
      r_out   <= '0;
    end else begin
      for (int i = 0; i < SIZE; i++)
        r_q[i] <= w_next[i];
      r_count <= w_nextCount;
      r_free  <= CNT_W'(SIZE) - w_nextCount;
      r_out   <= w_nextOut;
    end
  end
endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench: queue-based reference model plus directed
// scenarios with literal expectations, then randomized traffic.
module tb_issue_queue;
  import issue_queue_pkg::*;

  localparam int SIZE    = 8;
  localparam int NUM_WBS = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_WBS-1:0] wb_has;
  RES_UOp             wb_uop [NUM_WBS];
  BranchProv          br;
  logic               stall;
  IS_UOp              out_uop;

  issue_queue_if #(.SIZE(SIZE)) ifc ();

  issue_queue #(.SIZE(SIZE), .NUM_WBS(NUM_WBS)) dut (
    .clk            (clk),
    .rst            (rst),
    .enq            (ifc),
    .IN_wbHasResult (wb_has),
    .IN_wbUOp       (wb_uop),
    .IN_branch      (br),
    .IN_stall       (stall),
    .OUT_uop        (out_uop)
  );

  always #5 clk = ~clk;

  typedef struct {
    IS_UOp uop;
    bit    rA;
    bit    rB;
  } ment_t;

  ment_t mq[$];
  IS_UOp mout;
  bit    m_acc;
  int    n_cmp = 0;
  int    n_err = 0;
  SqN    next_sqn;

  function automatic bit younger(SqN a, SqN b);
    int d;
    d = (int'(a) - int'(b)) & ((1 << SQN_W) - 1);
    return d != 0 && d < (1 << (SQN_W - 1));
  endfunction

  function automatic bit wake(Tag t);
    if (t[TAG_W-1]) return 1'b0;
    for (int j = 0; j < NUM_WBS; j++)
      if (wb_has[j] && wb_uop[j].tagDst == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // next state from current inputs, evaluated just before the edge
  task automatic model_step();
    bit    rdy_pre;
    bit    hit;
    int    k;
    IS_UOp s;
    ment_t e;
    m_acc = 1'b0;
    if (rst) begin
      mq.delete();
      mout = '0;
      return;
    end
    rdy_pre = mq.size() < SIZE;
    hit = mout.valid && br.taken && younger(mout.sqN, br.sqN);
    if (!stall || hit) begin
      k = -1;
      foreach (mq[i])
        if (k < 0 && mq[i].rA && mq[i].rB) k = i;
      mout = '0;
      if (k >= 0) begin
        s = mq[k].uop;
        mq.delete(k);
        if (!(br.taken && younger(s.sqN, br.sqN))) begin
          mout = s;
          mout.valid = 1'b1;
        end
      end
    end
    foreach (mq[i]) begin
      if (wake(mq[i].uop.tagA)) mq[i].rA = 1'b1;
      if (wake(mq[i].uop.tagB)) mq[i].rB = 1'b1;
    end
    if (br.taken)
      for (int i = mq.size() - 1; i >= 0; i--)
        if (younger(mq[i].uop.sqN, br.sqN)) mq.delete(i);
    if (ifc.IN_valid && rdy_pre
        && !(br.taken && younger(ifc.IN_uop.sqN, br.sqN))) begin
      e.uop = ifc.IN_uop;
      e.rA  = ifc.IN_availA || ifc.IN_uop.tagA[TAG_W-1]
              || wake(ifc.IN_uop.tagA);
      e.rB  = ifc.IN_availB || ifc.IN_uop.tagB[TAG_W-1]
              || ifc.IN_uop.immB || wake(ifc.IN_uop.tagB);
      mq.push_back(e);
      m_acc = 1'b1;
    end
  endtask

  task automatic compare();
    chk("out_valid", 64'(out_uop.valid), 64'(mout.valid));
    if (mout.valid) chk("out_uop", 64'(out_uop), 64'(mout));
    chk("out_free", 64'(ifc.OUT_free), 64'(SIZE - mq.size()));
    chk("out_ready", 64'(ifc.OUT_ready), 64'(mq.size() < SIZE));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic idle();
    ifc.IN_valid  = 1'b0;
    ifc.IN_uop    = '0;
    ifc.IN_availA = 1'b0;
    ifc.IN_availB = 1'b0;
    wb_has        = '0;
    for (int j = 0; j < NUM_WBS; j++) wb_uop[j] = '0;
    br            = '0;
  endtask

  task automatic put(SqN s, Tag ta, bit av_a, Tag tb, bit imm);
    ifc.IN_valid       = 1'b1;
    ifc.IN_uop         = '0;
    ifc.IN_uop.valid   = 1'b1;
    ifc.IN_uop.sqN     = s;
    ifc.IN_uop.tagA    = ta;
    ifc.IN_uop.tagB    = tb;
    ifc.IN_uop.immB    = imm;
    ifc.IN_uop.tagDst  = 7'($urandom_range(0, 63));
    ifc.IN_uop.op      = 8'($urandom);
    ifc.IN_availA      = av_a;
    ifc.IN_availB      = 1'b0;
  endtask

  function automatic Tag rtag();
    if ($urandom_range(0, 3) == 0) return {1'b1, 6'($urandom)};
    return 7'($urandom_range(0, 15));
  endfunction

  initial begin
    idle();
    stall = 1'b0;
    rst   = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    chk("rst_free", 64'(ifc.OUT_free), 64'd8);
    chk("rst_ready", 64'(ifc.OUT_ready), 64'd1);
    chk("rst_outv", 64'(out_uop.valid), 64'd0);

    put(7'd0, 7'h45, 1'b0, 7'h12, 1'b1);
    cycle();
    chk("enq_free7", 64'(ifc.OUT_free), 64'd7);
    chk("enq_outv0", 64'(out_uop.valid), 64'd0);
    idle();
    cycle();
    chk("enq_issue", 64'({out_uop.valid, out_uop.sqN}), 64'({1'b1, 7'd0}));
    chk("enq_free8", 64'(ifc.OUT_free), 64'd8);

    put(7'd3, 7'd12, 1'b0, 7'h40, 1'b0);
    cycle();
    put(7'd4, 7'h45, 1'b0, 7'h40, 1'b0);
    cycle();
    idle();
    cycle();
    chk("wk_B_first", 64'({out_uop.valid, out_uop.sqN}), 64'({1'b1, 7'd4}));
    wb_has[2]        = 1'b1;
    wb_uop[2].tagDst = 7'd12;
    cycle();
    chk("wk_gap", 64'(out_uop.valid), 64'd0);
    idle();
    cycle();
    chk("wk_A_next", 64'({out_uop.valid, out_uop.sqN}), 64'({1'b1, 7'd3}));

    for (int s = 5; s <= 12; s++) begin
      put(7'(s), 7'd20, 1'b0, 7'h40, 1'b0);
      cycle();
    end
    chk("full_ready", 64'(ifc.OUT_ready), 64'd0);
    chk("full_free", 64'(ifc.OUT_free), 64'd0);
    put(7'd13, 7'h45, 1'b0, 7'h40, 1'b0);
    cycle();
    chk("full_9th", 64'(ifc.OUT_free), 64'd0);
    idle();
    br = '{taken: 1'b1, sqN: 7'd4};
    cycle();
    chk("flush_all", 64'(ifc.OUT_free), 64'd8);

    idle();
    put(7'd5, 7'h45, 1'b0, 7'h40, 1'b0);
    cycle();
    put(7'd6, 7'h45, 1'b0, 7'h40, 1'b0);
    cycle();
    chk("st_issue5", 64'({out_uop.valid, out_uop.sqN}), 64'({1'b1, 7'd5}));
    idle();
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("st_hold", 64'({out_uop.valid, out_uop.sqN}), 64'({1'b1, 7'd5}));
      chk("st_free", 64'(ifc.OUT_free), 64'd7);
    end
    stall = 1'b0;
    cycle();
    chk("st_release", 64'({out_uop.valid, out_uop.sqN}), 64'({1'b1, 7'd6}));

    for (int s = 10; s <= 12; s++) begin
      put(7'(s), 7'd30, 1'b0, 7'h40, 1'b0);
      cycle();
    end
    put(7'd13, 7'h45, 1'b0, 7'h40, 1'b0);
    cycle();
    idle();
    cycle();
    chk("fl_out13", 64'({out_uop.valid, out_uop.sqN}), 64'({1'b1, 7'd13}));
    stall = 1'b1;
    put(7'd14, 7'h45, 1'b0, 7'h40, 1'b0);
    br = '{taken: 1'b1, sqN: 7'd11};
    cycle();
    chk("fl_outv", 64'(out_uop.valid), 64'd0);
    chk("fl_free6", 64'(ifc.OUT_free), 64'd6);
    idle();
    stall            = 1'b0;
    wb_has[0]        = 1'b1;
    wb_uop[0].tagDst = 7'd30;
    cycle();
    idle();
    cycle();
    chk("fl_keep10", 64'({out_uop.valid, out_uop.sqN}), 64'({1'b1, 7'd10}));
    cycle();
    chk("fl_keep11", 64'({out_uop.valid, out_uop.sqN}), 64'({1'b1, 7'd11}));
    chk("fl_free8", 64'(ifc.OUT_free), 64'd8);

    put(7'd126, 7'd40, 1'b0, 7'h40, 1'b0);
    cycle();
    put(7'd1, 7'd40, 1'b0, 7'h40, 1'b0);
    cycle();
    idle();
    br = '{taken: 1'b1, sqN: 7'd127};
    cycle();
    chk("wrap_free7", 64'(ifc.OUT_free), 64'd7);
    idle();
    wb_has[1]        = 1'b1;
    wb_uop[1].tagDst = 7'd40;
    cycle();
    idle();
    cycle();
    chk("wrap_126", 64'({out_uop.valid, out_uop.sqN}), 64'({1'b1, 7'd126}));
    cycle();
    chk("wrap_empty", 64'(ifc.OUT_free), 64'd8);

    next_sqn = 7'd2;
    for (int c = 0; c < 3000; c++) begin
      idle();
      rst   = ($urandom_range(0, 499) == 0);
      stall = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 9) < 6) begin
        put(next_sqn, rtag(), $urandom_range(0, 3) == 0,
            rtag(), $urandom_range(0, 4) == 0);
        ifc.IN_availB = ($urandom_range(0, 3) == 0);
      end
      for (int j = 0; j < NUM_WBS; j++) begin
        wb_has[j]        = ($urandom_range(0, 9) < 3);
        wb_uop[j].tagDst = 7'($urandom_range(0, 15))
                         | (($urandom_range(0, 7) == 0) ? 7'h40 : 7'h00);
        wb_uop[j].result = $urandom;
      end
      if (c % 32 == 31) begin
        br.taken = 1'b1;
        br.sqN   = next_sqn - 7'd40;
      end else if ($urandom_range(0, 19) == 0) begin
        br.taken = 1'b1;
        br.sqN   = next_sqn - 7'd1 - 7'($urandom_range(0, 9));
      end
      cycle();
      if (br.taken && !rst) next_sqn = br.sqN + 7'd1;
      else if (m_acc) next_sqn = next_sqn + 7'd1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
